// File: rtl/romload_boot_copier.sv
// ---------------------------------------------------------------------------
// romload_boot_copier
//
// Boot-initialisation stage between the picorv32 native memory port and the
// ROM/RAM memory. After reset it holds the CPU in reset and then runs three
// steps:
//   1. zero-fills CLEAR_WORDS words starting at CLEAR_BASE (.bss),
//   2. copies COPY_WORDS words from COPY_SRC (ROM LMA) to COPY_DST (RAM VMA)
//      as a read followed by a write per word,
//   3. releases the CPU and becomes a transparent bus pass-through.
// Every init transfer is followed by one idle cycle, except the last one.
//
// Optional feature (macro ROMLOAD_WRITE_PROTECT_EN): in pass-through mode,
// CPU writes below ROM_LIMIT are turned into reads and flagged on wp_fault.
// Without the macro, strobes pass unchanged and wp_fault is tied low.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   cpu_resetn           reset to the CPU, low until init completes
//   init_done            high once init completes, until the next reset
//   cpu_mem_*            picorv32 native memory port (CPU side)
//   mem_*                memory side of the same interface
//   wp_fault             one-cycle pulse when a ROM write is blocked
// ---------------------------------------------------------------------------
module romload_boot_copier #(
    parameter logic [31:0] COPY_SRC    = 32'h0001_0000,
    parameter logic [31:0] COPY_DST    = 32'h0001_0100,
    parameter int          COPY_WORDS  = 64,
    parameter logic [31:0] CLEAR_BASE  = 32'h0001_0200,
    parameter int          CLEAR_WORDS = 256
`ifdef ROMLOAD_WRITE_PROTECT_EN
    ,
    parameter logic [31:0] ROM_LIMIT   = 32'h0001_00FF
`endif
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        cpu_resetn,
    output logic        init_done,
    input  logic        cpu_mem_valid,
    input  logic        cpu_mem_instr,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wp_fault
);

    typedef enum logic [2:0] {CLEAR, COPY_RD, COPY_WR, GAP, DONE} state_t;

    localparam state_t AFTER_CLEAR = (COPY_WORDS != 0) ? COPY_RD : DONE;
    localparam state_t FIRST_STATE = (CLEAR_WORDS != 0) ? CLEAR : AFTER_CLEAR;
    localparam logic [19:0] CLEAR_LAST = 20'(CLEAR_WORDS - 1);
    localparam logic [19:0] COPY_LAST  = 20'(COPY_WORDS - 1);

    state_t      state;
    state_t      gap_next;
    state_t      follow;
    logic [19:0] count;
    logic [19:0] next_count;
    logic [31:0] data_q;
    logic        init_valid;
    logic [31:0] init_addr;
    logic [31:0] init_wdata;
    logic [3:0]  init_wstrb;
    logic        cpu_resetn_q;
    logic        init_done_q;
    logic        rom_block;

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [19:0] idx);
        logic [31:0] sum;
        sum = base + {10'd0, idx, 2'b00};
        return {sum[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] issue_addr(input state_t st, input logic [19:0] idx);
        case (st)
            CLEAR:   return word_addr(CLEAR_BASE, idx);
            COPY_RD: return word_addr(COPY_SRC, idx);
            default: return word_addr(COPY_DST, idx);
        endcase
    endfunction

    // Where the current issue state goes once its transfer completes, and the
    // word index to use there. Phase changes restart the index at zero.
    always_comb begin
        follow     = DONE;
        next_count = count;
        case (state)
            CLEAR: begin
                if (count == CLEAR_LAST) begin
                    follow     = AFTER_CLEAR;
                    next_count = '0;
                end else begin
                    follow     = CLEAR;
                    next_count = count + 20'd1;
                end
            end
            COPY_RD: begin
                follow = COPY_WR;
            end
            COPY_WR: begin
                if (count == COPY_LAST) begin
                    follow     = DONE;
                    next_count = '0;
                end else begin
                    follow     = COPY_RD;
                    next_count = count + 20'd1;
                end
            end
            default: begin
                follow = DONE;
            end
        endcase
    end

    // Init sequencer. An issue state entered with mem_valid low (only right
    // after reset) loads its request first; GAP loads the next request so
    // that each transfer costs exactly three cycles with a fast memory.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= FIRST_STATE;
            gap_next     <= FIRST_STATE;
            count        <= '0;
            data_q       <= '0;
            init_valid   <= 1'b0;
            init_addr    <= '0;
            init_wdata   <= '0;
            init_wstrb   <= '0;
            cpu_resetn_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            case (state)
                CLEAR, COPY_RD, COPY_WR: begin
                    if (!init_valid) begin
                        init_valid <= 1'b1;
                        init_addr  <= issue_addr(state, count);
                        init_wdata <= (state == COPY_WR) ? data_q : 32'd0;
                        init_wstrb <= (state == COPY_RD) ? 4'h0 : 4'hF;
                    end else if (mem_ready) begin
                        init_valid <= 1'b0;
                        count      <= next_count;
                        if (state == COPY_RD) begin
                            data_q <= mem_rdata;
                        end
                        if (follow == DONE) begin
                            state        <= DONE;
                            cpu_resetn_q <= 1'b1;
                            init_done_q  <= 1'b1;
                        end else begin
                            state    <= GAP;
                            gap_next <= follow;
                        end
                    end
                end
                GAP: begin
                    state      <= gap_next;
                    init_valid <= 1'b1;
                    init_addr  <= issue_addr(gap_next, count);
                    init_wdata <= (gap_next == COPY_WR) ? data_q : 32'd0;
                    init_wstrb <= (gap_next == COPY_RD) ? 4'h0 : 4'hF;
                end
                default: begin
                    state        <= DONE;
                    init_valid   <= 1'b0;
                    cpu_resetn_q <= 1'b1;
                    init_done_q  <= 1'b1;
                end
            endcase
        end
    end

`ifdef ROMLOAD_WRITE_PROTECT_EN
    assign rom_block = init_done_q && cpu_mem_valid && (|cpu_mem_wstrb) && (cpu_mem_addr < ROM_LIMIT);
    assign wp_fault  = rom_block && mem_ready;
`else
    assign rom_block = 1'b0;
    assign wp_fault  = 1'b0;
`endif

    // init_done_q selects the bus owner: the sequencer while initialising,
    // the CPU afterwards.
    assign cpu_resetn    = cpu_resetn_q;
    assign init_done     = init_done_q;
    assign mem_valid     = init_done_q ? cpu_mem_valid : init_valid;
    assign mem_instr     = init_done_q ? cpu_mem_instr : 1'b0;
    assign mem_addr      = init_done_q ? cpu_mem_addr  : init_addr;
    assign mem_wdata     = init_done_q ? cpu_mem_wdata : init_wdata;
    assign mem_wstrb     = init_done_q ? (rom_block ? 4'h0 : cpu_mem_wstrb) : init_wstrb;
    assign cpu_mem_ready = init_done_q && mem_ready;
    assign cpu_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_romload_boot_copier.sv
// ---------------------------------------------------------------------------
// tb_romload_boot_copier
//
// Directed bench for romload_boot_copier with CLEAR_WORDS=4, COPY_WORDS=3.
// A behavioural memory answers one cycle after it samples mem_valid, with an
// optional one-shot stall on a chosen address. A monitor logs every completed
// init transfer and counts idle-cycle, stability and early-ready violations.
// ---------------------------------------------------------------------------
module tb_romload_boot_copier;

    logic        clk;
    logic        resetn;
    logic        cpu_resetn;
    logic        init_done;
    logic        cpu_mem_valid;
    logic        cpu_mem_instr;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_rdata;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wp_fault;

    int vectors = 0;
    int miscompares = 0;

    romload_boot_copier #(
        .COPY_WORDS (3),
        .CLEAR_WORDS(4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cpu_resetn   (cpu_resetn),
        .init_done    (init_done),
        .cpu_mem_valid(cpu_mem_valid),
        .cpu_mem_instr(cpu_mem_instr),
        .cpu_mem_addr (cpu_mem_addr),
        .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb),
        .cpu_mem_ready(cpu_mem_ready),
        .cpu_mem_rdata(cpu_mem_rdata),
        .mem_valid    (mem_valid),
        .mem_instr    (mem_instr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .wp_fault     (wp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory shared by the model and the stimulus.
    logic [31:0] ram [logic [29:0]];
    logic        stall_armed = 1'b0;
    logic [31:0] stall_addr = 32'd0;
    int          delay_left = 0;

    always @(posedge clk) begin : mem_model
        logic [29:0] k;
        logic [31:0] cur;
        if (mem_ready) begin
            mem_ready <= 1'b0;
        end else if (mem_valid) begin
            if (stall_armed && mem_addr == stall_addr) begin
                stall_armed <= 1'b0;
                delay_left  <= 4;
            end else if (delay_left > 0) begin
                delay_left <= delay_left - 1;
            end else begin
                k   = mem_addr[31:2];
                cur = ram.exists(k) ? ram[k] : 32'd0;
                mem_ready <= 1'b1;
                mem_rdata <= cur;
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) cur[b*8 +: 8] = mem_wdata[b*8 +: 8];
                end
                if (mem_wstrb != 4'h0) ram[k] = cur;
            end
        end
    end

    // Monitor of the init-phase bus.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } xfer_t;

    xfer_t       log_q[$];
    int          gap_err = 0;
    int          stab_err = 0;
    int          ready_err = 0;
    int          gap_phase = 0;
    logic        wait_prev = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] prev_wdata = 32'd0;
    logic [3:0]  prev_wstrb = 4'd0;

    always @(posedge clk) begin
        if (!resetn) begin
            gap_phase <= 0;
            wait_prev <= 1'b0;
        end else if (!init_done) begin
            if (cpu_mem_ready) ready_err <= ready_err + 1;
            if (gap_phase == 1) begin
                if (mem_valid) gap_err <= gap_err + 1;
                gap_phase <= 2;
            end else if (gap_phase == 2) begin
                if (!mem_valid) gap_err <= gap_err + 1;
                gap_phase <= 0;
            end
            if (wait_prev && (!mem_valid || mem_addr != prev_addr ||
                              mem_wdata != prev_wdata || mem_wstrb != prev_wstrb))
                stab_err <= stab_err + 1;
            wait_prev  <= mem_valid && !mem_ready;
            prev_addr  <= mem_addr;
            prev_wdata <= mem_wdata;
            prev_wstrb <= mem_wstrb;
            if (mem_valid && mem_ready) begin
                log_q.push_back('{mem_addr, mem_wdata, mem_wstrb});
                gap_phase <= 1;
            end
        end
    end

    // Expected init transfer sequence (hand-written).
    logic [31:0] exp_addr  [0:9];
    logic [31:0] exp_wdata [0:9];
    logic [3:0]  exp_wstrb [0:9];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic fillGarbage();
        for (int i = 0; i < 4; i++) ram[30'((32'h0001_0200 >> 2) + i)] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) ram[30'((32'h0001_0100 >> 2) + i)] = 32'hEEEE_EEEE;
    endtask

    task automatic applyReset(input string tag);
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput({tag, "_rst_valid"}, 32'(mem_valid), 32'd0);
        checkOutput({tag, "_rst_cpu_resetn"}, 32'(cpu_resetn), 32'd0);
        checkOutput({tag, "_rst_init_done"}, 32'(init_done), 32'd0);
        checkOutput({tag, "_rst_wp_fault"}, 32'(wp_fault), 32'd0);
        checkOutput({tag, "_rst_cpu_ready"}, 32'(cpu_mem_ready), 32'd0);
        log_q.delete();
    endtask

    // Release reset and count edges from the first mem_valid cycle to init_done.
    task automatic applyStimulus(input string tag, input int expected_cycles);
        int n;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, "_first_valid"}, 32'(mem_valid), 32'd1);
        checkOutput({tag, "_first_addr"}, mem_addr, 32'h0001_0200);
        checkOutput({tag, "_first_instr"}, 32'(mem_instr), 32'd0);
        n = 0;
        while (init_done !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_init_cycles"}, 32'(n), 32'(expected_cycles));
        checkOutput({tag, "_cpu_resetn"}, 32'(cpu_resetn), 32'd1);
    endtask

    task automatic checkLog(input string tag);
        checkOutput({tag, "_log_size"}, 32'(log_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < log_q.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), log_q[i].addr, exp_addr[i]);
            checkOutput($sformatf("%s_wstrb%0d", tag, i), 32'(log_q[i].wstrb), 32'(exp_wstrb[i]));
            if (exp_wstrb[i] != 4'h0)
                checkOutput($sformatf("%s_wdata%0d", tag, i), log_q[i].wdata, exp_wdata[i]);
        end
        checkOutput({tag, "_gap_err"}, 32'(gap_err), 32'd0);
        checkOutput({tag, "_stab_err"}, 32'(stab_err), 32'd0);
        checkOutput({tag, "_ready_err"}, 32'(ready_err), 32'd0);
    endtask

    task automatic checkRam(input string tag);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("%s_bss%0d", tag, i), ram[30'((32'h0001_0200 >> 2) + i)], 32'd0);
        checkOutput({tag, "_data0"}, ram[30'(32'h0001_0100 >> 2)], 32'hDEAD_BEEF);
        checkOutput({tag, "_data1"}, ram[30'(32'h0001_0104 >> 2)], 32'h1234_5678);
        checkOutput({tag, "_data2"}, ram[30'(32'h0001_0108 >> 2)], 32'hCAFE_F00D);
    endtask

    // One CPU access in pass-through mode; checks forwarding and completion.
    task automatic cpuAccess(input string tag, input logic instr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb,
                             input logic [3:0] exp_wstrb_fwd, input logic exp_fault);
        int n;
        @(negedge clk);
        cpu_mem_valid = 1'b1;
        cpu_mem_instr = instr;
        cpu_mem_addr  = addr;
        cpu_mem_wdata = wdata;
        cpu_mem_wstrb = wstrb;
        #1;
        checkOutput({tag, "_fwd_valid"}, 32'(mem_valid), 32'd1);
        checkOutput({tag, "_fwd_instr"}, 32'(mem_instr), 32'(instr));
        checkOutput({tag, "_fwd_addr"}, mem_addr, addr);
        checkOutput({tag, "_fwd_wdata"}, mem_wdata, wdata);
        checkOutput({tag, "_fwd_wstrb"}, 32'(mem_wstrb), 32'(exp_wstrb_fwd));
        checkOutput({tag, "_idle_ready"}, 32'(cpu_mem_ready), 32'd0);
        n = 0;
        while (mem_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_mem_ready"}, 32'(mem_ready), 32'd1);
        checkOutput({tag, "_cpu_ready"}, 32'(cpu_mem_ready), 32'd1);
        checkOutput({tag, "_wp_fault"}, 32'(wp_fault), 32'(exp_fault));
        @(negedge clk);
        cpu_mem_valid = 1'b0;
        cpu_mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_wp_fault_after"}, 32'(wp_fault), 32'd0);
    endtask

    initial begin
        int n;
        resetn        = 1'b0;
        cpu_mem_valid = 1'b0;
        cpu_mem_instr = 1'b0;
        cpu_mem_addr  = 32'd0;
        cpu_mem_wdata = 32'd0;
        cpu_mem_wstrb = 4'h0;

        exp_addr = '{32'h0001_0200, 32'h0001_0204, 32'h0001_0208, 32'h0001_020C,
                     32'h0001_0000, 32'h0001_0100, 32'h0001_0004, 32'h0001_0104,
                     32'h0001_0008, 32'h0001_0108};
        exp_wdata = '{32'd0, 32'd0, 32'd0, 32'd0,
                      32'd0, 32'hDEAD_BEEF, 32'd0, 32'h1234_5678,
                      32'd0, 32'hCAFE_F00D};
        exp_wstrb = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'hF};

        ram[30'(32'h0001_0000 >> 2)] = 32'hDEAD_BEEF;
        ram[30'(32'h0001_0004 >> 2)] = 32'h1234_5678;
        ram[30'(32'h0001_0008 >> 2)] = 32'hCAFE_F00D;

        // Plain init: 3*(4+2*3)-1 = 29 cycles from first valid to init_done.
        $display("[TB] plain init");
        fillGarbage();
        applyReset("a");
        applyStimulus("a", 29);
        checkLog("a");
        checkRam("a");

        // Second clear write stalled by five extra cycles.
        $display("[TB] stalled clear write");
        fillGarbage();
        stall_addr  = 32'h0001_0204;
        stall_armed = 1'b1;
        applyReset("b");
        applyStimulus("b", 34);
        checkOutput("b_stall_used", 32'(stall_armed), 32'd0);
        checkLog("b");
        checkRam("b");

        // Reset pulse during the third copy read, then a full restart.
        $display("[TB] reset during copy");
        fillGarbage();
        applyReset("c");
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        while (!(mem_valid === 1'b1 && mem_addr == 32'h0001_0008 && mem_wstrb == 4'h0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("c_third_read_seen", 32'(mem_addr), 32'h0001_0008);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("c_abort_valid", 32'(mem_valid), 32'd0);
        checkOutput("c_abort_cpu_resetn", 32'(cpu_resetn), 32'd0);
        log_q.delete();
        fillGarbage();
        applyStimulus("c", 29);
        checkLog("c");
        checkRam("c");

        // Pass-through after init.
        $display("[TB] pass-through");
        ram[30'(32'h0000_0100 >> 2)] = 32'h600D_F00D;
        ram[30'(32'h0002_0000 >> 2)] = 32'h1111_1111;
        cpuAccess("rd100", 1'b1, 32'h0000_0100, 32'd0, 4'h0, 4'h0, 1'b0);
        checkOutput("rd100_rdata", cpu_mem_rdata, 32'h600D_F00D);
        cpuAccess("wr20000", 1'b0, 32'h0002_0000, 32'hA5A5_A5A5, 4'h3, 4'h3, 1'b0);
        checkOutput("wr20000_ram", ram[30'(32'h0002_0000 >> 2)], 32'h1111_A5A5);

        ram[30'(32'h0000_0200 >> 2)] = 32'h0BAD_C0DE;
`ifdef ROMLOAD_WRITE_PROTECT_EN
        cpuAccess("wp200", 1'b0, 32'h0000_0200, 32'hBAD0_BAD0, 4'hF, 4'h0, 1'b1);
        checkOutput("wp200_ram", ram[30'(32'h0000_0200 >> 2)], 32'h0BAD_C0DE);
        cpuAccess("wp10100", 1'b0, 32'h0001_0100, 32'h7777_7777, 4'hF, 4'hF, 1'b0);
        checkOutput("wp10100_ram", ram[30'(32'h0001_0100 >> 2)], 32'h7777_7777);
`else
        cpuAccess("nowp200", 1'b0, 32'h0000_0200, 32'hBAD0_BAD0, 4'hF, 4'hF, 1'b0);
        checkOutput("nowp200_ram", ram[30'(32'h0000_0200 >> 2)], 32'hBAD0_BAD0);
`endif

        checkOutput("final_init_done", 32'(init_done), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
